// File: rtl/backend_seq_ctrl.sv
// Power-up sequencer and serial gain-configuration slave for NUM_AMP amplifiers plus a VCO,
// with a windowed VCO edge counter for frequency measurement. Single clock domain (i_clk).
`timescale 1ns/1ps
module backend_seq_ctrl #(
  parameter int NUM_AMP  = 2,
  parameter int GAIN_W   = 3,
  parameter int VCO_DLY  = 2,
  parameter int AMP_DLY  = 10,
  parameter int RDY_DLY  = 10,
  parameter int MEAS_WIN = 20,
  parameter int CNT_W    = 7
) (
  input  logic                        i_clk,
  input  logic                        i_resetbAll,
  input  logic                        i_scsb,
  input  logic                        i_sclk,
  input  logic                        i_sdin,
  input  logic                        i_vco_clk,
  input  logic                        i_remeas,
  output logic                        o_resetbvco,
  output logic [NUM_AMP-1:0]          o_resetb_amp,
  output logic [NUM_AMP*GAIN_W-1:0]   o_gain,
  output logic                        o_ready,
  output logic                        o_frame_err,
  output logic [CNT_W-1:0]            o_freq_cnt,
  output logic                        o_freq_valid,
  output logic [2:0]                  dbg_state
);

  localparam int FRAME_W = NUM_AMP * GAIN_W;
  localparam int BC_W    = $clog2(FRAME_W + 2);
  localparam int DLY_MAX = (VCO_DLY > AMP_DLY) ? ((VCO_DLY > RDY_DLY) ? VCO_DLY : RDY_DLY)
                                               : ((AMP_DLY > RDY_DLY) ? AMP_DLY : RDY_DLY);
  localparam int TMR_W   = $clog2(DLY_MAX + 1);
  localparam int WIN_W   = $clog2(MEAS_WIN + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    VCO_WAIT = 3'd1,
    AMP_WAIT = 3'd2,
    RDY_WAIT = 3'd3,
    READY    = 3'd4
  } state_t;

  state_t state, state_n;

  logic [1:0] cs_sync, sclk_sync, sdin_sync, vco_sync;
  logic       cs_q, sclk_q, vco_q;
  logic       cs_s, sclk_s, sdin_s, vco_s;
  logic       cs_rise, cs_fall, sclk_rise, vco_rise;

  logic [FRAME_W-1:0] shift_reg;
  logic [BC_W-1:0]    bit_cnt;
  logic               commit, discard;

  logic [TMR_W-1:0]   tmr;
  logic               win_active, win_start;
  logic [WIN_W-1:0]   win_tmr;
  logic [CNT_W-1:0]   edge_cnt, edge_nxt;

  // Chip select idles high, so its synchroniser resets high to avoid a false frame end.
  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      cs_sync   <= 2'b11;
      cs_q      <= 1'b1;
      sclk_sync <= 2'b00;
      sclk_q    <= 1'b0;
      sdin_sync <= 2'b00;
      vco_sync  <= 2'b00;
      vco_q     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], i_scsb};
      cs_q      <= cs_sync[1];
      sclk_sync <= {sclk_sync[0], i_sclk};
      sclk_q    <= sclk_sync[1];
      sdin_sync <= {sdin_sync[0], i_sdin};
      vco_sync  <= {vco_sync[0], i_vco_clk};
      vco_q     <= vco_sync[1];
    end
  end

  assign cs_s      = cs_sync[1];
  assign sclk_s    = sclk_sync[1];
  assign sdin_s    = sdin_sync[1];
  assign vco_s     = vco_sync[1];
  assign cs_rise   = cs_s & ~cs_q;
  assign cs_fall   = ~cs_s & cs_q;
  assign sclk_rise = sclk_s & ~sclk_q;
  assign vco_rise  = vco_s & ~vco_q;

  assign commit  = cs_rise && (bit_cnt == BC_W'(FRAME_W));
  assign discard = cs_rise && (bit_cnt != BC_W'(FRAME_W));

  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      o_gain      <= '0;
      o_frame_err <= 1'b0;
    end else begin
      if (cs_rise || cs_fall) begin
        bit_cnt <= '0;
      end else if (sclk_rise && !cs_s) begin
        shift_reg <= FRAME_W'({shift_reg, sdin_s});
        if (bit_cnt != BC_W'(FRAME_W + 1)) bit_cnt <= bit_cnt + 1'b1;
      end
      if (commit) o_gain <= shift_reg;
      o_frame_err <= discard;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      state <= IDLE;
      tmr   <= '0;
    end else begin
      state <= state_n;
      if (state_n != state || state == IDLE || state == READY) tmr <= '0;
      else                                                     tmr <= tmr + 1'b1;
    end
  end

  always_comb begin
    state_n      = state;
    o_resetbvco  = 1'b0;
    o_resetb_amp = '0;
    o_ready      = 1'b0;
    case (state)
      IDLE: begin
        if (commit) state_n = VCO_WAIT;
      end
      VCO_WAIT: begin
        if (tmr == TMR_W'(VCO_DLY - 1)) state_n = AMP_WAIT;
      end
      AMP_WAIT: begin
        o_resetbvco = 1'b1;
        if (tmr == TMR_W'(AMP_DLY - 1)) state_n = RDY_WAIT;
      end
      RDY_WAIT: begin
        o_resetbvco  = 1'b1;
        o_resetb_amp = '1;
        if (tmr == TMR_W'(RDY_DLY - 1)) state_n = READY;
      end
      READY: begin
        o_resetbvco  = 1'b1;
        o_resetb_amp = '1;
        o_ready      = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign dbg_state = state;

  // The first window opens together with o_ready; later ones on an idle-time re-measure request.
  assign win_start = (state == RDY_WAIT && state_n == READY) ||
                     (state == READY && !win_active && i_remeas);
  assign edge_nxt  = (vco_rise && edge_cnt != {CNT_W{1'b1}}) ? edge_cnt + 1'b1 : edge_cnt;

  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      win_active   <= 1'b0;
      win_tmr      <= '0;
      edge_cnt     <= '0;
      o_freq_cnt   <= '0;
      o_freq_valid <= 1'b0;
    end else if (win_start) begin
      win_active   <= 1'b1;
      win_tmr      <= '0;
      edge_cnt     <= '0;
      o_freq_valid <= 1'b0;
    end else if (win_active) begin
      edge_cnt <= edge_nxt;
      if (win_tmr == WIN_W'(MEAS_WIN - 1)) begin
        win_active   <= 1'b0;
        o_freq_cnt   <= edge_nxt;
        o_freq_valid <= 1'b1;
      end else begin
        win_tmr <= win_tmr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_backend_seq_ctrl.sv
// Directed bench for backend_seq_ctrl: framing, startup sequence timing, measurement,
// re-measure, saturation (second instance with CNT_W=2, MEAS_WIN=40) and async reset.
`timescale 1ns/1ps
module tb_backend_seq_ctrl;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_VCO_WAIT = 3'd1;
  localparam logic [2:0] S_AMP_WAIT = 3'd2;
  localparam logic [2:0] S_RDY_WAIT = 3'd3;
  localparam logic [2:0] S_READY    = 3'd4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scsb = 1'b1, sclk = 1'b0, sdin = 1'b0;
  logic vco1 = 1'b0, vco2 = 1'b0;
  logic remeas = 1'b0, remeas2 = 1'b0;
  int   vco1_half = 40;
  int   vco2_half = 30;
  int   checks = 0;
  int   failures = 0;

  logic       resetbvco, ready, frame_err, freq_valid;
  logic [1:0] resetb_amp;
  logic [5:0] gain;
  logic [6:0] freq_cnt;
  logic [2:0] state;

  logic       d2_resetbvco, d2_ready, d2_frame_err, d2_freq_valid;
  logic [1:0] d2_resetb_amp;
  logic [5:0] d2_gain;
  logic [1:0] d2_freq_cnt;
  logic [2:0] d2_state;

  // clock / reset block
  always #5 clk = ~clk;
  initial forever begin #(vco1_half); vco1 = ~vco1; end
  initial forever begin #(vco2_half); vco2 = ~vco2; end

  backend_seq_ctrl dut (
    .i_clk(clk), .i_resetbAll(rst_n), .i_scsb(scsb), .i_sclk(sclk), .i_sdin(sdin),
    .i_vco_clk(vco1), .i_remeas(remeas),
    .o_resetbvco(resetbvco), .o_resetb_amp(resetb_amp), .o_gain(gain), .o_ready(ready),
    .o_frame_err(frame_err), .o_freq_cnt(freq_cnt), .o_freq_valid(freq_valid),
    .dbg_state(state)
  );

  backend_seq_ctrl #(.CNT_W(2), .MEAS_WIN(40)) dut2 (
    .i_clk(clk), .i_resetbAll(rst_n), .i_scsb(scsb), .i_sclk(sclk), .i_sdin(sdin),
    .i_vco_clk(vco2), .i_remeas(remeas2),
    .o_resetbvco(d2_resetbvco), .o_resetb_amp(d2_resetb_amp), .o_gain(d2_gain),
    .o_ready(d2_ready), .o_frame_err(d2_frame_err), .o_freq_cnt(d2_freq_cnt),
    .o_freq_valid(d2_freq_valid), .dbg_state(d2_state)
  );

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] bits, input int n);
    scsb = 1'b0;
    tick(4);
    for (int i = n - 1; i >= 0; i--) begin
      sdin = bits[i];
      sclk = 1'b0;
      tick(4);
      sclk = 1'b1;
      tick(4);
    end
    sclk = 1'b0;
    tick(4);
    scsb = 1'b1;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input logic [31:0] obs,
                           input logic [31:0] lo, input logic [31:0] hi);
    checks++;
    assert (!$isunknown(obs) && obs >= lo && obs <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0h expected_range=%0h..%0h", tag, obs, lo, hi);
    end
  endtask

  initial begin
    tick(3);
    check("rst_gain", 32'(gain), 32'h0);
    check("rst_resetbvco", 32'(resetbvco), 32'h0);
    check("rst_resetb_amp", 32'(resetb_amp), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_freq_valid", 32'(freq_valid), 32'h0);
    check("rst_freq_cnt", 32'(freq_cnt), 32'h0);
    check("rst_state", 32'(state), 32'(S_IDLE));
    rst_n = 1'b1;
    tick(5);

    // 5-bit frame: discarded
    send_frame(8'b0001_0110, 5);
    tick(2);
    check("f5_err_early", 32'(frame_err), 32'h0);
    tick(1);
    check("f5_err_pulse", 32'(frame_err), 32'h1);
    check("f5_gain", 32'(gain), 32'h0);
    check("f5_state", 32'(state), 32'(S_IDLE));
    tick(1);
    check("f5_err_drop", 32'(frame_err), 32'h0);
    tick(4);

    // 7-bit frame: discarded
    send_frame(8'b0101_1010, 7);
    tick(3);
    check("f7_err_pulse", 32'(frame_err), 32'h1);
    check("f7_gain", 32'(gain), 32'h0);
    check("f7_resetbvco", 32'(resetbvco), 32'h0);
    check("f7_state", 32'(state), 32'(S_IDLE));
    tick(1);
    check("f7_err_drop", 32'(frame_err), 32'h0);
    tick(4);

    // 6-bit frame 101101: commit and startup sequence
    send_frame(8'b0010_1101, 6);
    tick(2);
    check("c_gain_early", 32'(gain), 32'h0);
    tick(1);
    check("c_gain", 32'(gain), 32'h2d);
    check("c_state_vco", 32'(state), 32'(S_VCO_WAIT));
    check("c_err", 32'(frame_err), 32'h0);
    tick(1);
    check("c_resetbvco_early", 32'(resetbvco), 32'h0);
    tick(1);
    check("c_resetbvco", 32'(resetbvco), 32'h1);
    check("c_state_amp", 32'(state), 32'(S_AMP_WAIT));
    tick(9);
    check("c_amp_early", 32'(resetb_amp), 32'h0);
    tick(1);
    check("c_amp", 32'(resetb_amp), 32'h3);
    check("c_state_rdy", 32'(state), 32'(S_RDY_WAIT));
    tick(9);
    check("c_ready_early", 32'(ready), 32'h0);
    tick(1);
    check("c_ready", 32'(ready), 32'h1);
    check("c_state_ready", 32'(state), 32'(S_READY));
    check("c_valid_at_ready", 32'(freq_valid), 32'h0);

    // first measurement, VCO period 8 clocks
    tick(19);
    check("m1_valid_early", 32'(freq_valid), 32'h0);
    tick(1);
    check("m1_valid", 32'(freq_valid), 32'h1);
    check_rng("m1_cnt", 32'(freq_cnt), 32'd2, 32'd3);
    tick(19);
    check("sat_valid_early", 32'(d2_freq_valid), 32'h0);
    tick(1);
    check("sat_valid", 32'(d2_freq_valid), 32'h1);
    check("sat_cnt", 32'(d2_freq_cnt), 32'h3);

    // re-measure with VCO period 6 clocks; a second request mid-window is ignored
    vco1_half = 30;
    tick(10);
    remeas = 1'b1;
    tick(1);
    remeas = 1'b0;
    check("m2_valid_drop", 32'(freq_valid), 32'h0);
    check_rng("m2_cnt_hold", 32'(freq_cnt), 32'd2, 32'd3);
    tick(4);
    remeas = 1'b1;
    tick(1);
    remeas = 1'b0;
    tick(14);
    check("m2_valid_early", 32'(freq_valid), 32'h0);
    tick(1);
    check("m2_valid", 32'(freq_valid), 32'h1);
    check_rng("m2_cnt", 32'(freq_cnt), 32'd3, 32'd4);

    // commit while READY: gains only
    send_frame(8'b0001_0011, 6);
    tick(2);
    check("r_gain_early", 32'(gain), 32'h2d);
    tick(1);
    check("r_gain", 32'(gain), 32'h13);
    check("r_ready", 32'(ready), 32'h1);
    check("r_resetbvco", 32'(resetbvco), 32'h1);
    check("r_amp", 32'(resetb_amp), 32'h3);
    check("r_state", 32'(state), 32'(S_READY));

    // async reset while in AMP_WAIT
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    send_frame(8'b0010_1101, 6);
    tick(8);
    check("a_state_amp", 32'(state), 32'(S_AMP_WAIT));
    check("a_resetbvco_pre", 32'(resetbvco), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("a_gain", 32'(gain), 32'h0);
    check("a_resetbvco", 32'(resetbvco), 32'h0);
    check("a_amp", 32'(resetb_amp), 32'h0);
    check("a_ready", 32'(ready), 32'h0);
    check("a_frame_err", 32'(frame_err), 32'h0);
    check("a_freq_valid", 32'(freq_valid), 32'h0);
    check("a_freq_cnt", 32'(freq_cnt), 32'h0);
    check("a_state", 32'(state), 32'(S_IDLE));
    tick(2);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
